// File: rtl/dmem_pkg.sv
// Shared types for the data-memory sequencer: size codes, FSM states, latched request.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_MERGE,
    ST_RESP
  } dmem_seq_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] wdata;
    logic        port;
  } dmem_req_t;

  // Unsigned codes are load-only; halves need even, words need 4-byte alignment.
  function automatic logic req_legal(input logic [1:0] addr_lo, input logic we,
                                     input logic [2:0] ctrl);
    logic ok;
    case (ctrl)
      SZ_B:    ok = 1'b1;
      SZ_BU:   ok = !we;
      SZ_H:    ok = !addr_lo[0];
      SZ_HU:   ok = !addr_lo[0] && !we;
      SZ_W:    ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_sequencer_lane.sv
// dmem_lane_unit: combinational lane select/extend for loads and lane merge for sub-word stores.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  ctrl_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = word_i[{addr_lo_i[1], 4'b0000} +: 16];

    case (ctrl_i)
      SZ_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   load_o = {24'h0, byte_sel};
      SZ_H:    load_o = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   load_o = {16'h0, half_sel};
      default: load_o = word_i;
    endcase

    merge_o = word_i;
    case (ctrl_i[1:0])
      2'b00:   merge_o[{addr_lo_i, 3'b000} +: 8]      = wdata_i[7:0];
      2'b01:   merge_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_sequencer.sv
// Two-port round-robin sequencer for the single-port data memory.
// DMEM_SEQ_BYTE_STROBE_EN adds memBe_o and turns sub-word stores into single strobed writes.
module dmem_sequencer
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic                                clk_i,
  input  logic                                rstN_i,
  input  logic [NUM_REQ-1:0]                  reqValid_i,
  output logic [NUM_REQ-1:0]                  reqReady_o,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  reqAddr_i,
  input  logic [NUM_REQ-1:0]                  reqWe_i,
  input  logic [NUM_REQ-1:0][2:0]             reqCtrl_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  reqWdata_i,
  output logic [NUM_REQ-1:0]                  rspValid_o,
  output logic                                rspErr_o,
  output logic [DATA_WIDTH-1:0]               rspRdata_o,
  output logic [DATA_WIDTH-1:0]               memAddr_o,
  output logic                                memRe_o,
  output logic                                memWe_o,
  output logic [DATA_WIDTH-1:0]               memWdata_o,
`ifdef DMEM_SEQ_BYTE_STROBE_EN
  output logic [3:0]                          memBe_o,
`endif
  input  logic [DATA_WIDTH-1:0]               memRdata_i
);

  dmem_seq_state_e state_q, state_d;
  dmem_req_t       req_q, req_d;
  logic            last_q, last_d;
  logic            winner;
  logic            legal;
  logic [31:0]     lane_load;
  logic [31:0]     lane_merge;

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      last_q  <= last_d;
    end
  end

  // The port not granted last wins a tie.
  assign winner = (&reqValid_i) ? ~last_q : reqValid_i[1];
  assign legal  = req_legal(req_q.addr[1:0], req_q.we, req_q.ctrl);

  dmem_lane_unit u_lane (
    .word_i    (memRdata_i),
    .addr_lo_i (req_q.addr[1:0]),
    .ctrl_i    (req_q.ctrl),
    .wdata_i   (req_q.wdata),
    .load_o    (lane_load),
    .merge_o   (lane_merge)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    last_d     = last_q;
    reqReady_o = '0;
    rspValid_o = '0;
    rspErr_o   = 1'b0;
    rspRdata_o = '0;
    memAddr_o  = '0;
    memRe_o    = 1'b0;
    memWe_o    = 1'b0;
    memWdata_o = '0;
`ifdef DMEM_SEQ_BYTE_STROBE_EN
    memBe_o    = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if ((|reqValid_i) && rstN_i) begin
          reqReady_o[winner] = 1'b1;
          req_d.addr  = reqAddr_i[winner];
          req_d.we    = reqWe_i[winner];
          req_d.ctrl  = reqCtrl_i[winner];
          req_d.wdata = reqWdata_i[winner];
          req_d.port  = winner;
          last_d      = winner;
          state_d     = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        state_d = ST_RESP;
        if (legal) begin
          memAddr_o = {req_q.addr[31:2], 2'b00};
          if (!req_q.we) begin
            memRe_o = 1'b1;
          end else if (req_q.ctrl == SZ_W) begin
            memWe_o    = 1'b1;
            memWdata_o = req_q.wdata;
`ifdef DMEM_SEQ_BYTE_STROBE_EN
            memBe_o    = 4'b1111;
`endif
          end else begin
`ifdef DMEM_SEQ_BYTE_STROBE_EN
            memWe_o = 1'b1;
            if (req_q.ctrl[0]) begin
              memWdata_o = {2{req_q.wdata[15:0]}};
              memBe_o    = 4'b0011 << {req_q.addr[1], 1'b0};
            end else begin
              memWdata_o = {4{req_q.wdata[7:0]}};
              memBe_o    = 4'b0001 << req_q.addr[1:0];
            end
`else
            // Fetch the old word; MERGE patches the lane and writes it back.
            memRe_o = 1'b1;
            state_d = ST_MERGE;
`endif
          end
        end
      end

      ST_MERGE: begin
        memAddr_o  = {req_q.addr[31:2], 2'b00};
        memWe_o    = 1'b1;
        memWdata_o = lane_merge;
        state_d    = ST_RESP;
      end

      ST_RESP: begin
        rspValid_o[req_q.port] = 1'b1;
        rspErr_o               = !legal;
        if (legal && !req_q.we) rspRdata_o = lane_load;
        state_d                = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_sequencer.sv
// Scoreboard bench for dmem_sequencer with a behavioural single-port memory.
`timescale 1ns/1ps
module tb_dmem_sequencer;

  localparam int EW = 38;  // {lat[3:0], port, err, rdata[31:0]}
  localparam int WW = 68;  // {addr[31:0], data[31:0], be[3:0]}

  logic             clk_i = 1'b0;
  logic             rstN_i = 1'b0;
  logic [1:0]       reqValid_i, reqReady_o, reqWe_i, rspValid_o;
  logic [1:0][31:0] reqAddr_i, reqWdata_i;
  logic [1:0][2:0]  reqCtrl_i;
  logic             rspErr_o, memRe_o, memWe_o;
  logic [31:0]      rspRdata_o, memAddr_o, memWdata_o, memRdata_i;
`ifdef DMEM_SEQ_BYTE_STROBE_EN
  logic [3:0]       memBe_o;
`endif

  logic        r_valid [2];
  logic [31:0] r_addr  [2];
  logic        r_we    [2];
  logic [2:0]  r_ctrl  [2];
  logic [31:0] r_wdata [2];

  assign reqValid_i = {r_valid[1], r_valid[0]};
  assign reqAddr_i  = {r_addr[1], r_addr[0]};
  assign reqWe_i    = {r_we[1], r_we[0]};
  assign reqCtrl_i  = {r_ctrl[1], r_ctrl[0]};
  assign reqWdata_i = {r_wdata[1], r_wdata[0]};

  dmem_sequencer dut (
    .clk_i      (clk_i),
    .rstN_i     (rstN_i),
    .reqValid_i (reqValid_i),
    .reqReady_o (reqReady_o),
    .reqAddr_i  (reqAddr_i),
    .reqWe_i    (reqWe_i),
    .reqCtrl_i  (reqCtrl_i),
    .reqWdata_i (reqWdata_i),
    .rspValid_o (rspValid_o),
    .rspErr_o   (rspErr_o),
    .rspRdata_o (rspRdata_o),
    .memAddr_o  (memAddr_o),
    .memRe_o    (memRe_o),
    .memWe_o    (memWe_o),
    .memWdata_o (memWdata_o),
`ifdef DMEM_SEQ_BYTE_STROBE_EN
    .memBe_o    (memBe_o),
`endif
    .memRdata_i (memRdata_i)
  );

  // clock / reset / cycle count
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // memory model: read data appears the cycle after memRe_o
  logic [31:0] mem [0:1023];
  logic [31:0] mem_rd_q = '0;
  assign memRdata_i = mem_rd_q;
  always @(posedge clk_i) begin
    if (memWe_o) begin
`ifdef DMEM_SEQ_BYTE_STROBE_EN
      for (int b = 0; b < 4; b++)
        if (memBe_o[b]) mem[memAddr_o[11:2]][8*b +: 8] <= memWdata_o[8*b +: 8];
`else
      mem[memAddr_o[11:2]] <= memWdata_o;
`endif
    end
    if (memRe_o) mem_rd_q <= mem[memAddr_o[11:2]];
  end

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  logic [WW-1:0] wexp_q[$];
  int            grant_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            re_cnt = 0;
  int            we_cnt = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // monitor
  always @(negedge clk_i) begin
    if (rstN_i) begin
      if (reqReady_o != 2'b00) begin
        check("ready_onehot", 64'($onehot(reqReady_o)), 64'd1);
        grant_q.push_back(int'(reqReady_o[1]));
      end
      if (memRe_o) re_cnt++;
      if (memWe_o) we_cnt++;
      if (memRe_o || memWe_o)
        check("strobe_excl_addr_align", {62'd0, memRe_o & memWe_o, |memAddr_o[1:0]}, 64'd0);
      if (memWe_o) begin
        if (wexp_q.size() == 0) flag("unexpected_write");
        else begin
          logic [WW-1:0] w;
          w = wexp_q.pop_front();
          check("write_word", {memAddr_o, memWdata_o}, w[67:4]);
`ifdef DMEM_SEQ_BYTE_STROBE_EN
          check("write_be", 64'(memBe_o), 64'(w[3:0]));
`endif
        end
      end
      if (rspValid_o != 2'b00) begin
        if (exp_q.size() == 0) flag("unexpected_response");
        else begin
          logic [EW-1:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("rsp_data", {29'd0, rspValid_o, rspErr_o, rspRdata_o},
                {29'd0, (e[33] ? 2'b10 : 2'b01), e[32], e[31:0]});
          check("rsp_latency", 64'(cyc - a), 64'(e[37:34]));
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input int p, input logic [31:0] a, input logic we, input logic [2:0] c,
                       input logic [31:0] wd, input logic err, input logic [31:0] rd, input int lat);
    bit got;
    got = 1'b0;
    @(posedge clk_i); #1;
    r_valid[p] = 1'b1; r_addr[p] = a; r_we[p] = we; r_ctrl[p] = c; r_wdata[p] = wd;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_i);
      if (reqReady_o[p]) begin
        got = 1'b1;
        exp_q.push_back({lat[3:0], p[0], err, rd});
        acc_q.push_back(cyc);
      end
    end
    @(posedge clk_i); #1;
    r_valid[p] = 1'b0;
    if (!got) flag($sformatf("issue_timeout_port%0d", p));
  endtask

  task automatic expw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wexp_q.push_back({a, d, be});
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 40) begin
      @(negedge clk_i);
      i++;
    end
    if (exp_q.size() != 0) flag({name, "_drain_timeout"});
    repeat (2) @(negedge clk_i);
  endtask

  function automatic logic [63:0] outs_or();
    logic [63:0] v;
    v = 64'(reqReady_o) | 64'(rspValid_o) | 64'(rspErr_o) | 64'(rspRdata_o) | 64'(memAddr_o)
      | 64'(memRe_o) | 64'(memWe_o) | 64'(memWdata_o);
`ifdef DMEM_SEQ_BYTE_STROBE_EN
    v = v | 64'(memBe_o);
`endif
    return v;
  endfunction

  initial begin
    int re0, we0;
    int gpat;
    for (int p = 0; p < 2; p++) begin
      r_valid[p] = 1'b0; r_addr[p] = '0; r_we[p] = 1'b0; r_ctrl[p] = '0; r_wdata[p] = '0;
    end
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[32'h100 >> 2] = 32'h80FF7F01;
    mem[32'h200 >> 2] = 32'hAABBCCDD;
    mem[32'h204 >> 2] = 32'h11223344;

    repeat (2) @(negedge clk_i);
    check("reset_outputs", outs_or(), 64'd0);
    @(posedge clk_i); #1;
    rstN_i = 1'b1;

    // arbitration with both ports requesting from reset
    grant_q.delete();
    fork
      begin
        issue(0, 32'h100, 1'b0, 3'b010, 32'h0, 1'b0, 32'h80FF7F01, 2);
        issue(0, 32'h100, 1'b0, 3'b100, 32'h0, 1'b0, 32'h00000001, 2);
      end
      begin
        issue(1, 32'h200, 1'b0, 3'b010, 32'h0, 1'b0, 32'hAABBCCDD, 2);
        issue(1, 32'h200, 1'b0, 3'b101, 32'h0, 1'b0, 32'h0000CCDD, 2);
      end
    join
    drain("arb");
    gpat = 0;
    foreach (grant_q[i]) gpat = (gpat << 4) | grant_q[i];
    check("arb_order", {32'(grant_q.size()), 32'(gpat)}, {32'd4, 32'h0101});

    // sub-word loads
    issue(0, 32'h103, 1'b0, 3'b000, 32'h0, 1'b0, 32'hFFFFFF80, 2);
    issue(0, 32'h103, 1'b0, 3'b100, 32'h0, 1'b0, 32'h00000080, 2);
    issue(0, 32'h101, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0000007F, 2);
    issue(0, 32'h100, 1'b0, 3'b001, 32'h0, 1'b0, 32'h00007F01, 2);
    issue(0, 32'h102, 1'b0, 3'b101, 32'h0, 1'b0, 32'h000080FF, 2);
    issue(0, 32'h102, 1'b0, 3'b001, 32'h0, 1'b0, 32'hFFFF80FF, 2);
    drain("loads");

    // half store
    re0 = re_cnt;
`ifdef DMEM_SEQ_BYTE_STROBE_EN
    expw(32'h200, 32'h12341234, 4'b1100);
    issue(0, 32'h202, 1'b1, 3'b001, 32'h00001234, 1'b0, 32'h0, 2);
    drain("sh");
    check("sh_reads", 64'(re_cnt - re0), 64'd0);
`else
    expw(32'h200, 32'h1234CCDD, 4'b1111);
    issue(0, 32'h202, 1'b1, 3'b001, 32'h00001234, 1'b0, 32'h0, 3);
    drain("sh");
    check("sh_reads", 64'(re_cnt - re0), 64'd1);
`endif
    issue(0, 32'h200, 1'b0, 3'b010, 32'h0, 1'b0, 32'h1234CCDD, 2);
    drain("sh_readback");

    // illegal requests: error response, no memory strobes
    re0 = re_cnt; we0 = we_cnt;
    issue(0, 32'h105, 1'b0, 3'b010, 32'h0, 1'b1, 32'h0, 2);
    issue(0, 32'h101, 1'b0, 3'b001, 32'h0, 1'b1, 32'h0, 2);
    issue(1, 32'h100, 1'b0, 3'b011, 32'h0, 1'b1, 32'h0, 2);
    issue(0, 32'h100, 1'b1, 3'b100, 32'hFF, 1'b1, 32'h0, 2);
    issue(1, 32'h100, 1'b1, 3'b111, 32'hFF, 1'b1, 32'h0, 2);
    drain("illegal");
    check("illegal_no_strobes", {32'(re_cnt - re0), 32'(we_cnt - we0)}, 64'd0);

    // word store then signed half load
    expw(32'h300, 32'hDEADBEEF, 4'b1111);
    issue(1, 32'h300, 1'b1, 3'b010, 32'hDEADBEEF, 1'b0, 32'h0, 2);
    issue(0, 32'h302, 1'b0, 3'b001, 32'h0, 1'b0, 32'hFFFFDEAD, 2);
    drain("sw_lh");

    // reset during ACCESS of a byte store
    we0 = we_cnt;
    @(posedge clk_i); #1;
    r_valid[0] = 1'b1; r_addr[0] = 32'h204; r_we[0] = 1'b1; r_ctrl[0] = 3'b000; r_wdata[0] = 32'h55;
    @(negedge clk_i);
    check("rst_accept", 64'(reqReady_o), 64'd1);
    @(posedge clk_i); #1;
    r_valid[0] = 1'b0;
    #1 rstN_i = 1'b0;
    @(negedge clk_i);
    check("rst_outputs_a", outs_or(), 64'd0);
    @(negedge clk_i);
    check("rst_outputs_b", outs_or(), 64'd0);
    @(posedge clk_i); #1;
    rstN_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check("rst_no_write", 64'(we_cnt - we0), 64'd0);
    issue(0, 32'h204, 1'b0, 3'b010, 32'h0, 1'b0, 32'h11223344, 2);
    drain("rst_readback");

    // byte store after reset
`ifdef DMEM_SEQ_BYTE_STROBE_EN
    expw(32'h204, 32'h55555555, 4'b0010);
    issue(0, 32'h205, 1'b1, 3'b000, 32'h00000055, 1'b0, 32'h0, 2);
`else
    expw(32'h204, 32'h11225544, 4'b1111);
    issue(0, 32'h205, 1'b1, 3'b000, 32'h00000055, 1'b0, 32'h0, 3);
`endif
    issue(1, 32'h204, 1'b0, 3'b010, 32'h0, 1'b0, 32'h11225544, 2);
    drain("sb");

    check("leftover_expect", {32'(exp_q.size()), 32'(wexp_q.size())}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_sequencer.md
# dmem_sequencer

Sequencer and arbiter in front of the single-port data memory. Two requesters share the memory: port 0 is the core load/store unit and port 1 is the DMA/debug port. The block grants one requester at a time and checks alignment. It produces word-aligned memory cycles, including read-modify-write for sub-word stores. It returns sign- or zero-extended load data, or a store acknowledge, to the requester that was granted.

## Interface
- DATA_WIDTH, 32: data and address width; the design supports only 32.
- NUM_REQ, 2: number of requesters; the design supports only 2.
- clk_i  in  1  clock; all logic is rising-edge.
- rstN_i  in  1  asynchronous reset, active low.
- reqValid_i  in  [NUM_REQ]  request valid, one bit per port.
- reqReady_o  out  [NUM_REQ]  request accepted; one-hot or zero.
- reqAddr_i  in  [NUM_REQ][32]  byte address.
- reqWe_i  in  [NUM_REQ]  1 = store.
- reqCtrl_i  in  [NUM_REQ][3]  funct3-style size code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- reqWdata_i  in  [NUM_REQ][32]  store data, right-aligned.
- rspValid_o  out  [NUM_REQ]  one-cycle response pulse to the granted port.
- rspErr_o  out  1  response is an error; qualified by rspValid_o.
- rspRdata_o  out  32  extended load data; 0 for stores and errors.
- memAddr_o  out  32  word address; bits [1:0] always 0.
- memRe_o / memWe_o  out  1 / 1  memory read and write strobes.
- memWdata_o  out  32  full write word.
- memRdata_i  in  32  read data, valid in the cycle after memRe_o.
- memBe_o  out  4  byte strobes; this port exists only with DMEM_SEQ_BYTE_STROBE_EN.

## Operation
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - If any reqValid_i is high, round-robin picks the winner.
  - The last-granted register resets to 1, so port 0 wins the first contest.
  - reqReady_o[winner] is driven combinationally in the same cycle.
  - addr, we, ctrl, wdata and the port are latched.
  - The next state is ACCESS.
- Legality is checked on the latched request:
  - Half access with addr[0]=1 is illegal.
  - Word access with addr[1:0]≠0 is illegal.
  - Codes 011, 110 and 111 are illegal.
  - A store with code 100 or 101 is illegal.
  - An illegal request goes ACCESS→RESP with rspErr_o=1 and no memory strobe.
- ACCESS:
  - Load: memRe_o=1, then RESP.
  - Word store: memWe_o=1 with memWdata_o=wdata, then RESP.
  - Sub-word store: memRe_o=1, then MERGE.
- MERGE:
  - Replace byte lane addr[1:0], or half lane addr[1], of memRdata_i with the low bits of wdata.
  - memWe_o=1, then RESP.
- RESP:
  - rspValid_o[port]=1 for one cycle.
  - Load: select the lane from memRdata_i (captured at the end of ACCESS) and extend it. Codes 000 and 001 sign-extend; 100 and 101 zero-extend.
  - Next state is IDLE.
- Requests are accepted only in IDLE. A requester whose reqValid_i is held high is not served until the next IDLE.
- Round-robin: if both ports are valid in IDLE, the port not granted last wins.
- No response backpressure; requesters must accept rspValid_o.

## Timing
- All outputs reset to 0; the state resets to IDLE and the last-granted register to 1.
- Reset mid-operation: the state returns to IDLE immediately. No further strobes are issued and no response is given. A completed memWe_o is not undone. A pending read-modify-write that has not reached MERGE performs no write.
- Request accepted in cycle T:
  - Load: rspValid_o at T+2.
  - Word store: write at T+1, rspValid_o at T+2.
  - Sub-word store: read at T+1, write at T+2, rspValid_o at T+3.
  - Illegal request: rspValid_o at T+2, no strobes.
- Minimum issue interval: 3 cycles, or 4 for a sub-word store.
- memRe_o and memWe_o are never high in the same cycle.
- memAddr_o equals {addr[31:2],2'b00} whenever either strobe is high.

## Configuration
- DMEM_SEQ_BYTE_STROBE_EN defined:
  - The memBe_o port exists.
  - A sub-word store is a single write in ACCESS with wdata replicated across lanes. memBe_o is 0001<<addr[1:0] for a byte and 0011<<{addr[1],0} for a half.
  - MERGE is unreachable, and the store latency matches a word store.
  - A word store drives memBe_o=1111.
- Not defined: there is no memBe_o port and sub-word stores use read-modify-write as above.

## Structure
- The shared package dmem_pkg holds:
  - size-code constants (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU);
  - the state enum dmem_seq_state_e;
  - the latched-request struct dmem_req_t.
- One sub-module, dmem_lane_unit, is purely combinational. Given the word, addr[1:0], code and wdata, it outputs the extended load value and the merged store word. It is instantiated once.

## Test plan
- Load byte, signed and unsigned: memory word at 0x100 = 0x80FF7F01; port 0 reads code 000 at 0x103 → rspRdata 0xFFFFFF80 at T+2. Code 100 at the same address → 0x00000080.
- Store half via read-modify-write (macro off): word at 0x200 = 0xAABBCCDD; sh 0x1234 to 0x202 → read at T+1, write 0x1234CCDD at T+2, rspValid at T+3. With the macro on: a single write at T+1 with memBe 1100.
- Misaligned access: lw at 0x105 → rspErr=1 and rspRdata=0 at T+2, with no memRe or memWe ever high.
- Arbitration: both ports valid continuously from reset → grants go 0,1,0,1. Each reqReady is a single pulse, only in IDLE.
- Word store then load: sw 0xDEADBEEF to 0x300 on port 1, then lh code 001 at 0x302 on port 0 → 0xFFFFDEAD.
- Reset mid read-modify-write: assert rstN_i during ACCESS of an sb → no write, no rspValid; all outputs are 0 while reset is asserted.
